// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver assembling DATA_BYTE bytes per word
// Mid-bit sampling from a clock-per-bit counter, with framing, gap-timeout and abort errors.
module uart_rx_core #(
  parameter int DATA_BYTE   = 1,
  parameter int CLK_PER_BIT = 16,
  parameter int GAP_BITS    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   rxEn,
  input  logic                   rx_bit,
  output logic [DATA_BYTE*8-1:0] rx_data,
  output logic                   rxDone,
  output logic                   rxBusy,
  output logic                   rxError
);
  localparam int HALF    = CLK_PER_BIT / 2;
  localparam int GAP_CYC = GAP_BITS * CLK_PER_BIT;
  localparam int CNT_MAX = (GAP_CYC > CLK_PER_BIT) ? GAP_CYC : CLK_PER_BIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_END  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(DATA_BYTE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_FIN, S_GAP} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q, hist_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [2:0]             byte_q, byte_d;
  logic [7:0]             shift_q, shift_d;
  logic                   stop_q, stop_d;
  logic [DATA_BYTE*8-1:0] word_q, word_d;
  logic [DATA_BYTE*8-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   start_edge;
  logic                   abort;

  assign start_edge = hist_q & ~sync2_q;
  assign abort      = ~rxEn & (state_q != S_IDLE);

  // Line flops reset high so a low line at reset release cannot look like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx_bit;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      word_q  <= word_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxEn && start_edge) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bit_d = '0;
          if (!sync2_q) state_d = S_DATA;
          else          state_d = (byte_q != 3'd0) ? S_GAP : S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          stop_d  = sync2_q;
          state_d = S_FIN;
        end
      end
      // One cycle after the stop sample: commit or discard, never losing a fresh start edge.
      S_FIN: begin
        cnt_d = '0;
        if (stop_q && byte_q != LAST_BYTE) begin
          byte_d  = byte_q + 1'b1;
          state_d = start_edge ? S_START : S_GAP;
        end else begin
          byte_d  = '0;
          state_d = (stop_q && start_edge) ? S_START : S_IDLE;
        end
      end
      S_GAP: begin
        if (start_edge) begin
          cnt_d   = '0;
          state_d = S_START;
        end else if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          byte_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      byte_d  = '0;
    end
  end

  always_comb begin
    word_d = word_q;
    data_d = data_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    if (abort) begin
      err_d  = (byte_q != 3'd0) || (state_q inside {S_DATA, S_STOP, S_FIN});
      word_d = '0;
    end else if (state_q == S_FIN) begin
      if (stop_q) begin
        for (int i = 0; i < DATA_BYTE; i++) begin
          if (byte_q == 3'(i)) word_d[i*8 +: 8] = shift_q;
        end
        if (byte_q == LAST_BYTE) begin
          data_d = word_d;
          done_d = 1'b1;
          word_d = '0;
        end
      end else begin
        err_d  = 1'b1;
        word_d = '0;
      end
    end else if (state_q == S_GAP && !start_edge && cnt_q == GAP_END) begin
      err_d  = 1'b1;
      word_d = '0;
    end
  end

  assign rx_data = data_q;
  assign rxDone  = done_q;
  assign rxBusy  = busy_q;
  assign rxError = err_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Synthesizable UART receiver. It is the DUT-side consumer of the serial bit stream the RX driver produces, and the producer of the rxDone/rxBusy/rxError/data signals the RX monitor checks.
- Samples the asynchronous serial line at mid-bit using a clock-per-bit counter.
- Deframes 8N1 bytes, LSB first, and assembles DATA_BYTE bytes into one parallel word.
- Flags framing and inter-byte timeout errors.

Parameters:
- DATA_BYTE, 1: bytes per assembled word. Range 1..8.
- CLK_PER_BIT, 16: i_clk cycles per serial bit. Minimum 4. HALF = CLK_PER_BIT/2 (integer division).
- GAP_BITS, 16: maximum idle time between bytes of one word, in bit times. Timeout = GAP_BITS*CLK_PER_BIT cycles.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge
- i_rst  input  1  reset; asynchronous, active-high
- rxEn  input  1  receiver enable
- rx_bit  input  1  serial line; asynchronous to i_clk; idle high
- rx_data  output  DATA_BYTE*8  assembled word; byte 0 (first received) in [7:0]
- rxDone  output  1  one-cycle pulse: rx_data holds a new complete word
- rxBusy  output  1  high while a frame/word is in progress
- rxError  output  1  one-cycle pulse: framing error, timeout, or aborted word

Behaviour:
- Reset (asynchronous, active-high):
  - rx_data=0, rxDone=0, rxBusy=0, rxError=0.
  - State=IDLE, byte count=0, counters=0.
  - Both synchronizer flops and the edge-history flop set to 1, so no false start occurs after reset.
  - Reset mid-frame discards all partial data; no done or error pulse is produced.
- Input path: 2-flop synchronizer on rx_bit, then one history flop. Start edge = history 1 and synchronized value 0.
- Timing reference: t0 is the first posedge at which rx_bit is sampled low.
  - Edge detected and START entered at t0+2.
  - Start bit sampled at t0+2+HALF.
  - Data bit i (i = 0..7) sampled at t0+2+HALF+(i+1)*CLK_PER_BIT.
  - Stop bit sampled at t0+2+HALF+9*CLK_PER_BIT.
  - rxDone is asserted the following cycle.
  - DATA_BYTE=1, CLK_PER_BIT=16: rxDone at t0+155.
- States:
  - IDLE: leaves IDLE on a start edge while rxEn=1; an edge with rxEn=0 is ignored. rxBusy goes high on the cycle START is entered.
  - START: at HALF count, synchronized line 0 means go to DATA. Line 1 is a false start: return to IDLE with no error; rxBusy drops if byte count=0.
  - DATA: shift in 8 bits LSB first, one every CLK_PER_BIT cycles, into a byte shift register.
  - STOP: stop sample 1 stores the byte in slot [byte_cnt], then:
    - if byte_cnt = DATA_BYTE-1: update rx_data with the full word, pulse rxDone, clear byte_cnt, drop rxBusy, go to IDLE;
    - otherwise: byte_cnt+1 and go to GAP.
  - STOP, framing error (stop sample 0): pulse rxError, discard the whole word, clear byte_cnt, drop rxBusy, go to IDLE. A new start edge still requires the line to return high first, so a break does not retrigger.
  - GAP: rxBusy stays high; waits for a start edge, which goes to START. If GAP_BITS*CLK_PER_BIT cycles pass with no edge: pulse rxError, discard, clear byte_cnt, go to IDLE.
- rx_data is updated only on the rxDone cycle and holds until the next rxDone. Partial words are never visible on rx_data.
- rxEn deasserted in START, DATA, STOP or GAP:
  - Next cycle: IDLE, rxBusy=0, byte_cnt=0, partial data discarded.
  - rxError pulses only if byte_cnt>0 or the state was DATA/STOP; a START abort is silent.
- rxDone and rxError are never high in the same cycle. Each is exactly one cycle wide.
- A start edge landing on the same cycle rxDone pulses is not lost: the edge flop is evaluated in IDLE on the next cycle, while the history still shows 1→0.

Test Plan:
- DATA_BYTE=1, CLK_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rxDone one cycle at t0+155, rx_data=0xA5, rxBusy high t0+2..t0+154, rxError never high.
- DATA_BYTE=2, send 0x34 then 0x12 with 3 idle bit times between -> single rxDone after the second stop, rx_data=0x1234; rxBusy held high through the gap.
- Send 0x5A with stop bit driven 0 -> rxError one-cycle pulse at the stop+1 cycle, no rxDone, rx_data keeps its previous value, rxBusy=0 afterwards.
- 3-cycle low glitch on idle line -> rxBusy high then low by t0+3+HALF, no rxDone, no rxError; a following 0x3C frame is received correctly.
- DATA_BYTE=2, send 0x77 then idle 17 bit times (GAP_BITS=16) -> rxError pulse at 16*16 cycles after GAP entry, no rxDone, byte count restarts with the next frame.
- Assert i_rst during data bit 4 of 0xFF, release, then send 0x81 -> all outputs 0 immediately on reset, no pulses, next rxDone with rx_data=0x81. Repeat with rxEn dropped mid-byte -> rxBusy low next cycle, rxError pulse, then 0x81 received after rxEn is re-asserted.
